// File: rtl/rect_fill_engine_pkg.sv
// rtl/rect_fill_engine_pkg.sv - shared widths, FSM state and point type for the rectangle fill engine
package rect_fill_engine_pkg;
   localparam int COORD_W = 8;
   localparam int COLOR_W = 4;
   localparam int CNT_W   = 2*COORD_W+1;
   localparam logic [COORD_W-1:0] SCREEN_MAX = {COORD_W{1'b1}};

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } point_t;

   function automatic logic [COORD_W-1:0] coord_min(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [COORD_W-1:0] coord_max(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
      return (a < b) ? b : a;
   endfunction
endpackage

// File: rtl/rect_scan_counter.sv
// rtl/rect_scan_counter.sv - row-major x/y raster counter over a latched rectangle
module rect_scan_counter
   import rect_fill_engine_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   step,
   input  point_t lo,
   input  point_t hi,
   output point_t pos,
   output logic   last
);
   logic [COORD_W-1:0] x_min;
   point_t             hi_q;

   // Steps stop at the latched max, so a rectangle touching 255 never wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos   <= '0;
         x_min <= '0;
         hi_q  <= '0;
      end else if (load) begin
         pos   <= lo;
         x_min <= lo.x;
         hi_q  <= hi;
      end else if (step) begin
         if (pos.x != hi_q.x) begin
            pos.x <= pos.x + COORD_W'(1);
         end else if (pos.y != hi_q.y) begin
            pos.x <= x_min;
            pos.y <= pos.y + COORD_W'(1);
         end
      end
   end

   assign last = (pos.x == hi_q.x) && (pos.y == hi_q.y);
endmodule

// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - turns one rectangle request into a row-major stream of pixel writes
module rect_fill_engine
   import rect_fill_engine_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fill_trigger,
   input  logic [COORD_W-1:0] corner_a_x,
   input  logic [COORD_W-1:0] corner_a_y,
   input  logic [COORD_W-1:0] corner_b_x,
   input  logic [COORD_W-1:0] corner_b_y,
   input  logic [COLOR_W-1:0] fill_color,
   input  logic               abort,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic [COORD_W-1:0] wr_x,
   output logic [COORD_W-1:0] wr_y,
   output logic [COLOR_W-1:0] wr_color,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   pix_count
);
   state_t state;
   point_t corner_a, corner_b, lo, hi, pos;
   logic   last, accept;

   assign accept = wr_valid && wr_ready;
   assign lo     = {coord_min(corner_a.x, corner_b.x), coord_min(corner_a.y, corner_b.y)};
   assign hi     = {coord_max(corner_a.x, corner_b.x), coord_max(corner_a.y, corner_b.y)};
   assign wr_x   = pos.x;
   assign wr_y   = pos.y;

   rect_scan_counter u_scan (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (state == SETUP),
      .step  ((state == RUN) && accept),
      .lo    (lo),
      .hi    (hi),
      .pos   (pos),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pix_count <= '0;
         wr_color  <= '0;
         corner_a  <= '0;
         corner_b  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (fill_trigger && !abort) begin
                  corner_a <= {corner_a_x, corner_a_y};
                  corner_b <= {corner_b_x, corner_b_y};
                  wr_color <= fill_color;
                  busy     <= 1'b1;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               pix_count <= '0;
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  wr_valid <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               // A beat accepted in the abort cycle still counts.
               if (accept) pix_count <= pix_count + CNT_W'(1);
               if (abort) begin
                  wr_valid <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (accept && last) begin
                  wr_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
